mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage_pkg.sv | 29 ++
 rtl/mem_wb_stage.sv | 150 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared types, opcode constants and memory-class helpers for mem_wb_stage
package mem_wb_stage_pkg;

    typedef logic [9:0] opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    localparam opcode_t OP_LOAD      = 10'h040;
    localparam opcode_t OP_STORE     = 10'h048;
    localparam opcode_t OP_PUSH_BASE = 10'h050;
    localparam opcode_t OP_POP_BASE  = 10'h058;
    localparam opcode_t OP_IMUL      = 10'h0F7;

    // POP occupies an 8-aligned block of eight opcodes, so only bits [9:3] matter
    function automatic logic is_mem_read(input opcode_t op);
        return (op == OP_LOAD) || (op[9:3] == OP_POP_BASE[9:3]);
    endfunction

    // PUSH occupies an 8-aligned block of eight opcodes, so only bits [9:3] matter
    function automatic logic is_mem_write(input opcode_t op);
        return (op == OP_STORE) || (op[9:3] == OP_PUSH_BASE[9:3]);
    endfunction

endpackage

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory access / write-back stage; MEM_WB_WIDE_WB_EN enables IMUL high-half write-back
import mem_wb_stage_pkg::*;

module mem_wb_stage (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         exe_mem,
    input  logic [9:0]   opcode,
    input  logic [127:0] result,
    input  logic [63:0]  rflags_in,
    input  logic [63:0]  mem_addr,
    input  logic [3:0]   dst_reg,
    output logic         mem_blocked,
    output logic         mem_req_valid,
    input  logic         mem_req_ready,
    output logic         mem_req_write,
    output logic [63:0]  mem_req_addr,
    output logic [63:0]  mem_req_data,
    input  logic         mem_resp_valid,
    input  logic [63:0]  mem_resp_data,
    output logic         wb_en,
    output logic [3:0]   wb_reg,
    output logic [63:0]  wb_data,
    output logic         wb_hi_en,
    output logic [63:0]  wb_hi_data,
    output logic         rflags_wen,
    output logic [63:0]  rflags_out,
    output logic [63:0]  retired_cnt
);

    state_t        state;
    state_t        state_next;
    opcode_t       op_q;
    logic [63:0]   res_q;
    logic [63:0]   flags_q;
    logic [63:0]   addr_q;
    logic [3:0]    dst_q;
    logic [63:0]   rdata_q;
    logic [63:0]   cnt_q;

    // State register; reset returns to IDLE immediately, abandoning any transaction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode; every output is qualified by registered state
    always_comb begin
        state_next    = state;
        mem_blocked   = (state != ST_IDLE);
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;
        wb_en         = 1'b0;
        wb_reg        = '0;
        wb_data       = '0;
        rflags_wen    = 1'b0;
        rflags_out    = '0;
        case (state)
            ST_IDLE: begin
                if (exe_mem) begin
                    state_next = (is_mem_read(opcode) || is_mem_write(opcode)) ? ST_REQ : ST_WB;
                end
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_write = is_mem_write(op_q);
                mem_req_addr  = addr_q;
                mem_req_data  = res_q;
                if (mem_req_ready) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    state_next = ST_WB;
                end
            end
            ST_WB: begin
                wb_en      = !is_mem_write(op_q);
                wb_reg     = dst_q;
                wb_data    = is_mem_read(op_q) ? rdata_q : res_q;
                rflags_wen = 1'b1;
                rflags_out = flags_q;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

`ifdef MEM_WB_WIDE_WB_EN
    logic [63:0] res_hi_q;

    // High half of the execute result, kept only when wide write-back exists
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_hi_q <= '0;
        end else if (state == ST_IDLE && exe_mem) begin
            res_hi_q <= result[127:64];
        end
    end

    assign wb_hi_en   = (state == ST_WB) && (op_q == OP_IMUL);
    assign wb_hi_data = wb_hi_en ? res_hi_q : 64'd0;
`else
    logic unused_result_hi;
    assign unused_result_hi = ^result[127:64];
    assign wb_hi_en   = 1'b0;
    assign wb_hi_data = 64'd0;
`endif

    // Instruction capture, load-data latch and retirement counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q    <= '0;
            res_q   <= '0;
            flags_q <= '0;
            addr_q  <= '0;
            dst_q   <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (state == ST_IDLE && exe_mem) begin
                op_q    <= opcode;
                res_q   <= result[63:0];
                flags_q <= rflags_in;
                addr_q  <= mem_addr;
                dst_q   <= dst_reg;
            end
            // Write acks carry no data, so only reads update the latch
            if (state == ST_WAIT && mem_resp_valid && is_mem_read(op_q)) begin
                rdata_q <= mem_resp_data;
            end
            // Counted on the edge entering WB so the count is visible alongside wb_en;
            // natural 64-bit wrap covers 2^64-1 -> 0
            if (state_next == ST_WB && state != ST_WB) begin
                cnt_q <= cnt_q + 64'd1;
            end
        end
    end

    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

    logic         clk;
    logic         reset_n;
    logic         exe_mem;
    logic [9:0]   opcode;
    logic [127:0] result;
    logic [63:0]  rflags_in;
    logic [63:0]  mem_addr;
    logic [3:0]   dst_reg;
    logic         mem_blocked;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_write;
    logic [63:0]  mem_req_addr;
    logic [63:0]  mem_req_data;
    logic         mem_resp_valid;
    logic [63:0]  mem_resp_data;
    logic         wb_en;
    logic [3:0]   wb_reg;
    logic [63:0]  wb_data;
    logic         wb_hi_en;
    logic [63:0]  wb_hi_data;
    logic         rflags_wen;
    logic [63:0]  rflags_out;
    logic [63:0]  retired_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    mem_wb_stage dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .exe_mem        (exe_mem),
        .opcode         (opcode),
        .result         (result),
        .rflags_in      (rflags_in),
        .mem_addr       (mem_addr),
        .dst_reg        (dst_reg),
        .mem_blocked    (mem_blocked),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .wb_en          (wb_en),
        .wb_reg         (wb_reg),
        .wb_data        (wb_data),
        .wb_hi_en       (wb_hi_en),
        .wb_hi_data     (wb_hi_data),
        .rflags_wen     (rflags_wen),
        .rflags_out     (rflags_out),
        .retired_cnt    (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic [9:0] op, input logic [127:0] res, input logic [63:0] addr,
                         input logic [3:0] dst, input logic [63:0] flags);
        exe_mem   = 1'b1;
        opcode    = op;
        result    = res;
        mem_addr  = addr;
        dst_reg   = dst;
        rflags_in = flags;
    endtask

    initial begin
        reset_n        = 1'b0;
        exe_mem        = 1'b0;
        opcode         = '0;
        result         = '0;
        rflags_in      = '0;
        mem_addr       = '0;
        dst_reg        = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        tick();
        tick();

        check("rst_blocked",   64'(mem_blocked),   64'd0);
        check("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_wb_en",     64'(wb_en),         64'd0);
        check("rst_rflags_wen",64'(rflags_wen),    64'd0);
        check("rst_cnt",       retired_cnt,        64'd0);
        reset_n = 1'b1;
        tick();

        // ADD: non-memory, write-back one cycle after capture
        issue(10'h001, 128'h5, 64'h0, 4'd3, 64'h11);
        check("add_blocked_pre", 64'(mem_blocked), 64'd0);
        tick();
        exe_mem = 1'b0;
        check("add_wb_en",   64'(wb_en),      64'd1);
        check("add_wb_reg",  64'(wb_reg),     64'd3);
        check("add_wb_data", wb_data,         64'h5);
        check("add_cnt",     retired_cnt,     64'd1);
        check("add_rfl_wen", 64'(rflags_wen), 64'd1);
        check("add_rfl_out", rflags_out,      64'h11);
        check("add_hi_en",   64'(wb_hi_en),   64'd0);
        tick();
        check("add_idle_wb_en",   64'(wb_en),       64'd0);
        check("add_idle_blocked", 64'(mem_blocked), 64'd0);

        // LOAD: ready high, response three cycles after the request is taken
        mem_req_ready = 1'b1;
        issue(10'h040, 128'h0, 64'h1000, 4'd5, 64'h22);
        tick();
        exe_mem = 1'b0;
        check("ld_req_valid", 64'(mem_req_valid), 64'd1);
        check("ld_req_addr",  mem_req_addr,       64'h1000);
        check("ld_req_write", 64'(mem_req_write), 64'd0);
        check("ld_blocked",   64'(mem_blocked),   64'd1);
        tick();
        mem_req_ready = 1'b0;
        check("ld_req_once",  64'(mem_req_valid), 64'd0);
        for (int i = 0; i < 2; i++) begin
            check("ld_wait_blocked", 64'(mem_blocked), 64'd1);
            check("ld_wait_wb_en",   64'(wb_en),       64'd0);
            tick();
        end
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hDEAD;
        tick();
        mem_resp_valid = 1'b0;
        check("ld_wb_en",   64'(wb_en),  64'd1);
        check("ld_wb_reg",  64'(wb_reg), 64'd5);
        check("ld_wb_data", wb_data,     64'hDEAD);
        check("ld_cnt",     retired_cnt, 64'd2);
        tick();
        check("ld_idle_blocked", 64'(mem_blocked), 64'd0);

        // PUSH: ready withheld four cycles, request must stay stable
        issue(10'h050, 128'h42, 64'h2000, 4'd6, 64'h33);
        tick();
        exe_mem = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("push_valid", 64'(mem_req_valid), 64'd1);
            check("push_write", 64'(mem_req_write), 64'd1);
            check("push_addr",  mem_req_addr,       64'h2000);
            check("push_data",  mem_req_data,       64'h42);
            tick();
        end
        mem_req_ready = 1'b1;
        check("push_valid_rdy", 64'(mem_req_valid), 64'd1);
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hBAD;
        tick();
        mem_resp_valid = 1'b0;
        check("push_wb_en",   64'(wb_en),      64'd0);
        check("push_rfl_wen", 64'(rflags_wen), 64'd1);
        check("push_rfl_out", rflags_out,      64'h33);
        check("push_wb_data", wb_data,         64'h42);
        check("push_cnt",     retired_cnt,     64'd3);
        tick();

        // POP followed by an ADD held on exe_mem through the stall
        mem_req_ready = 1'b1;
        issue(10'h05F, 128'h0, 64'h3000, 4'd7, 64'h44);
        tick();
        issue(10'h002, 128'h99, 64'h0, 4'd2, 64'h55);
        check("pop_req_addr", mem_req_addr, 64'h3000);
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'h77;
        tick();
        mem_resp_valid = 1'b0;
        check("pop_wb_data", wb_data,     64'h77);
        check("pop_wb_reg",  64'(wb_reg), 64'd7);
        check("pop_cnt",     retired_cnt, 64'd4);
        tick();
        check("held_idle_blocked", 64'(mem_blocked), 64'd0);
        check("held_idle_wb_en",   64'(wb_en),       64'd0);
        tick();
        exe_mem = 1'b0;
        check("held_wb_en",   64'(wb_en),  64'd1);
        check("held_wb_data", wb_data,     64'h99);
        check("held_wb_reg",  64'(wb_reg), 64'd2);
        check("held_cnt",     retired_cnt, 64'd5);
        tick();
        tick();
        check("held_once_cnt", retired_cnt, 64'd5);
        check("held_once_en",  64'(wb_en),  64'd0);

        // Reset while waiting for a load response, then a stray response
        issue(10'h040, 128'h0, 64'h4000, 4'd8, 64'h66);
        tick();
        exe_mem = 1'b0;
        tick();
        mem_req_ready = 1'b0;
        check("rw_in_wait", 64'(mem_blocked), 64'd1);
        reset_n = 1'b0;
        #1;
        check("rw_blocked",   64'(mem_blocked),   64'd0);
        check("rw_req_valid", 64'(mem_req_valid), 64'd0);
        check("rw_cnt",       retired_cnt,        64'd0);
        check("rw_wb_en",     64'(wb_en),         64'd0);
        tick();
        reset_n        = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hEEEE;
        tick();
        mem_resp_valid = 1'b0;
        check("stray_wb_en",   64'(wb_en),       64'd0);
        check("stray_blocked", 64'(mem_blocked), 64'd0);
        check("stray_cnt",     retired_cnt,      64'd0);
        issue(10'h003, 128'hA, 64'h0, 4'd1, 64'h0);
        tick();
        exe_mem = 1'b0;
        check("post_rst_data", wb_data,     64'hA);
        check("post_rst_cnt",  retired_cnt, 64'd1);
        tick();

        // IMUL: high half only written back when wide write-back is built in
        issue(10'h0F7, {64'h7, 64'h21}, 64'h0, 4'd4, 64'h0);
        tick();
        exe_mem = 1'b0;
        check("imul_wb_en",   64'(wb_en), 64'd1);
        check("imul_wb_data", wb_data,    64'h21);
`ifdef MEM_WB_WIDE_WB_EN
        check("imul_hi_en",   64'(wb_hi_en), 64'd1);
        check("imul_hi_data", wb_hi_data,    64'h7);
`else
        check("imul_hi_en",   64'(wb_hi_en), 64'd0);
        check("imul_hi_data", wb_hi_data,    64'h0);
`endif
        tick();
        check("imul_hi_idle", 64'(wb_hi_en), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
